// File: rtl/descending_emitter_if.sv
// Load/emit bus for descending_emitter.
// DESCENDING_EMITTER_OVERFLOW_EN adds the sticky overflow flag.
interface descending_emitter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
);
    logic [DATA_WIDTH-1:0]   din;
    logic                    din_valid;
    logic                    start;
    logic [DATA_WIDTH-1:0]   dout;
    logic                    dout_valid;
    logic                    last;
    logic                    busy;
    logic [$clog2(DEPTH):0]  count;
`ifdef DESCENDING_EMITTER_OVERFLOW_EN
    logic                    overflow;

    modport master (
        output din, din_valid, start,
        input  dout, dout_valid, last, busy, count, overflow
    );
    modport slave (
        input  din, din_valid, start,
        output dout, dout_valid, last, busy, count, overflow
    );
`else
    modport master (
        output din, din_valid, start,
        input  dout, dout_valid, last, busy, count
    );
    modport slave (
        input  din, din_valid, start,
        output dout, dout_valid, last, busy, count
    );
`endif
endinterface

// File: rtl/descending_emitter.sv
// Buffers up to DEPTH words, then emits them largest-first.
// DESCENDING_EMITTER_OVERFLOW_EN adds a sticky dropped-word flag.
module descending_emitter #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    descending_emitter_if.slave  bus
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    typedef enum logic {LOAD, EMIT} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          count_q, count_d;
    logic [CW-1:0]          sent_q, sent_d;
    logic [DEPTH-1:0]       done_q, done_d;
    logic [DATA_WIDTH-1:0]  dout_q, dout_d;
    logic                   dout_valid_q, dout_valid_d;
    logic                   last_q, last_d;
    logic                   busy_q, busy_d;
    logic [DATA_WIDTH-1:0]  buf_q [DEPTH];

    logic                   wr_en;
    logic [IW-1:0]          wr_idx;
    logic                   found;
    logic [IW-1:0]          pick_idx;
    logic [DATA_WIDTH-1:0]  pick_val;

    // Strict '>' keeps the lowest index on ties.
    always_comb begin
        found    = 1'b0;
        pick_idx = '0;
        pick_val = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count_q && !done_q[i]
                && (!found || buf_q[i] > pick_val)) begin
                found    = 1'b1;
                pick_idx = IW'(i);
                pick_val = buf_q[i];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        sent_d       = sent_q;
        done_d       = done_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        last_d       = 1'b0;
        busy_d       = busy_q;
        wr_en        = 1'b0;
        wr_idx       = count_q[IW-1:0];
        unique case (state_q)
            LOAD: begin
                if (bus.din_valid && count_q != CW'(DEPTH)) begin
                    wr_en   = 1'b1;
                    count_d = count_q + CW'(1);
                end
                if (bus.start && count_d != '0) begin
                    state_d = EMIT;
                    busy_d  = 1'b1;
                    sent_d  = '0;
                    done_d  = '0;
                end
            end
            EMIT: begin
                dout_d           = pick_val;
                dout_valid_d     = 1'b1;
                done_d[pick_idx] = 1'b1;
                sent_d           = sent_q + CW'(1);
                if (sent_q == count_q - CW'(1)) begin
                    last_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = LOAD;
                    count_d = '0;
                    done_d  = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= LOAD;
            count_q      <= '0;
            sent_q       <= '0;
            done_q       <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            last_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            sent_q       <= sent_d;
            done_q       <= done_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            last_q       <= last_d;
            busy_q       <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            buf_q[wr_idx] <= bus.din;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.last       = last_q;
    assign bus.busy       = busy_q;
    assign bus.count      = count_q;

`ifdef DESCENDING_EMITTER_OVERFLOW_EN
    logic ovf_q, ovf_d;

    // Entering EMIT clears the flag even if a word is dropped that cycle.
    always_comb begin
        ovf_d = ovf_q;
        if (state_q == LOAD && bus.din_valid
            && count_q == CW'(DEPTH)) begin
            ovf_d = 1'b1;
        end
        if (state_q == LOAD && state_d == EMIT) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.overflow = ovf_q;
`endif
endmodule

// File: tb/tb_descending_emitter.sv
// Self-checking bench for descending_emitter: vector table,
// directed corner sequences and a randomized reference model.
module tb_descending_emitter;
    localparam int DW    = 32;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    descending_emitter_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    descending_emitter #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic          dv;
        logic [DW-1:0] din;
        logic          st;
        logic          e_dv;
        logic [DW-1:0] e_dout;
        logic          e_last;
        logic          e_busy;
        int            e_count;
    } vec_t;

    vec_t tv[$];

    task automatic chk(string name, logic [DW-1:0] act,
                       logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(logic r, logic dv, logic [DW-1:0] d, logic s);
        reset         = r;
        bus.din_valid = dv;
        bus.din       = d;
        bus.start     = s;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(string tag, logic dv, logic [DW-1:0] dout,
                           logic lst, logic bsy, int cnt);
        chk({tag, ".dout_valid"}, DW'(bus.dout_valid), DW'(dv));
        chk({tag, ".dout"}, bus.dout, dout);
        chk({tag, ".last"}, DW'(bus.last), DW'(lst));
        chk({tag, ".busy"}, DW'(bus.busy), DW'(bsy));
        chk({tag, ".count"}, DW'(bus.count), DW'(cnt));
    endtask

    function automatic void v(logic dv, logic [DW-1:0] din, logic st,
                              logic e_dv, logic [DW-1:0] e_dout,
                              logic e_last, logic e_busy, int e_count);
        vec_t r;
        r.dv = dv; r.din = din; r.st = st;
        r.e_dv = e_dv; r.e_dout = e_dout; r.e_last = e_last;
        r.e_busy = e_busy; r.e_count = e_count;
        tv.push_back(r);
    endfunction

    // Reference model: loaded words in arrival order, emission list
    // produced by a stable descending insertion sort.
    logic [DW-1:0] m_words[$];
    logic [DW-1:0] m_pend[$];
    bit            m_emit;
    logic [DW-1:0] m_dout;
    bit            m_dv, m_last, m_busy, m_ovf;

    task automatic model(bit r, bit dv, logic [DW-1:0] d, bit s);
        int pos;
        m_dv   = 0;
        m_last = 0;
        if (r) begin
            m_words.delete();
            m_pend.delete();
            m_emit = 0; m_dout = '0; m_busy = 0; m_ovf = 0;
        end else if (m_emit) begin
            m_dout = m_pend.pop_front();
            m_dv   = 1;
            if (m_pend.size() == 0) begin
                m_last = 1; m_emit = 0; m_busy = 0;
                m_words.delete();
            end
        end else begin
            if (dv && m_words.size() < DEPTH) m_words.push_back(d);
            else if (dv) m_ovf = 1;
            if (s && m_words.size() > 0) begin
                m_pend.delete();
                foreach (m_words[i]) begin
                    pos = m_pend.size();
                    for (int j = 0; j < m_pend.size(); j++) begin
                        if (m_pend[j] < m_words[i]) begin
                            pos = j;
                            break;
                        end
                    end
                    m_pend.insert(pos, m_words[i]);
                end
                m_emit = 1; m_busy = 1; m_ovf = 0;
            end
        end
    endtask

    initial begin
        logic [DW-1:0] got[$];
        int            guard;

        drive(1, 0, '0, 0);
        tick;
        chk_all("reset", 0, '0, 0, 0, 0);
`ifdef DESCENDING_EMITTER_OVERFLOW_EN
        chk("reset.overflow", DW'(bus.overflow), '0);
`endif
        drive(0, 0, '0, 0);

        // Six-word emission
        v(1, 'h02, 0, 0, 'h00, 0, 0, 1);
        v(1, 'h06, 0, 0, 'h00, 0, 0, 2);
        v(1, 'h00, 0, 0, 'h00, 0, 0, 3);
        v(1, 'h0e, 0, 0, 'h00, 0, 0, 4);
        v(1, 'h0c, 0, 0, 'h00, 0, 0, 5);
        v(1, 'h01, 0, 0, 'h00, 0, 0, 6);
        v(0, 'h00, 1, 0, 'h00, 0, 1, 6);
        v(0, 'h00, 0, 1, 'h0e, 0, 1, 6);
        v(0, 'h00, 0, 1, 'h0c, 0, 1, 6);
        v(0, 'h00, 0, 1, 'h06, 0, 1, 6);
        v(0, 'h00, 0, 1, 'h02, 0, 1, 6);
        v(0, 'h00, 0, 1, 'h01, 0, 1, 6);
        v(0, 'h00, 0, 1, 'h00, 1, 0, 0);
        v(0, 'h00, 0, 0, 'h00, 0, 0, 0);
        // Duplicates, then a single-word emission
        v(1, 'h05, 0, 0, 'h00, 0, 0, 1);
        v(1, 'h05, 0, 0, 'h00, 0, 0, 2);
        v(1, 'h03, 0, 0, 'h00, 0, 0, 3);
        v(0, 'h00, 1, 0, 'h00, 0, 1, 3);
        v(0, 'h00, 0, 1, 'h05, 0, 1, 3);
        v(0, 'h00, 0, 1, 'h05, 0, 1, 3);
        v(0, 'h00, 0, 1, 'h03, 1, 0, 0);
        v(1, 'h07, 0, 0, 'h03, 0, 0, 1);
        v(0, 'h00, 1, 0, 'h03, 0, 1, 1);
        v(0, 'h00, 0, 1, 'h07, 1, 0, 0);
        // din and start together; inputs ignored mid-emission
        v(1, 'h01, 0, 0, 'h07, 0, 0, 1);
        v(1, 'h0f, 1, 0, 'h07, 0, 1, 2);
        v(1, 'hff, 1, 1, 'h0f, 0, 1, 2);
        v(0, 'h00, 0, 1, 'h01, 1, 0, 0);
        v(0, 'h00, 0, 0, 'h01, 0, 0, 0);

        foreach (tv[i]) begin
            drive(0, tv[i].dv, tv[i].din, tv[i].st);
            tick;
            chk_all($sformatf("vec%0d", i), tv[i].e_dv, tv[i].e_dout,
                    tv[i].e_last, tv[i].e_busy, tv[i].e_count);
        end

        // Start on an empty buffer is ignored
        drive(0, 0, '0, 1);
        tick;
        drive(0, 0, '0, 0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("empty_start.dv%0d", i),
                DW'(bus.dout_valid), '0);
            chk($sformatf("empty_start.busy%0d", i), DW'(bus.busy), '0);
            tick;
        end

        // Overfill: ninth word dropped
        for (int i = 1; i <= 9; i++) begin
            drive(0, 1, DW'(i), 0);
            tick;
        end
        drive(0, 0, '0, 0);
        chk("overfill.count", DW'(bus.count), DW'(DEPTH));
`ifdef DESCENDING_EMITTER_OVERFLOW_EN
        chk("overfill.overflow", DW'(bus.overflow), 'd1);
`endif
        drive(0, 0, '0, 1);
        tick;
        drive(0, 0, '0, 0);
`ifdef DESCENDING_EMITTER_OVERFLOW_EN
        chk("overfill.ovf_clear", DW'(bus.overflow), '0);
`endif
        got.delete();
        guard = 0;
        while (guard < 20) begin
            tick;
            guard++;
            if (bus.dout_valid) got.push_back(bus.dout);
            if (bus.last) break;
        end
        chk("overfill.nwords", DW'(got.size()), DW'(DEPTH));
        foreach (got[i]) begin
            chk($sformatf("overfill.w%0d", i), got[i], DW'(8 - i));
        end

        // Reset while the third word is on dout
        for (int i = 1; i <= 6; i++) begin
            drive(0, 1, DW'(i * 16), 0);
            tick;
        end
        drive(0, 0, '0, 1);
        tick;
        drive(0, 0, '0, 0);
        tick;
        tick;
        tick;
        chk("abort.third", bus.dout, 'h40);
        drive(1, 1, 'h77, 1);
        tick;
        drive(0, 0, '0, 0);
        chk_all("abort", 0, '0, 0, 0, 0);
        drive(0, 1, 'h03, 0);
        tick;
        drive(0, 1, 'h09, 1);
        tick;
        drive(0, 0, '0, 0);
        tick;
        chk_all("after_abort.w0", 1, 'h09, 0, 1, 2);
        tick;
        chk_all("after_abort.w1", 1, 'h03, 1, 0, 0);

        // Randomized run against the reference model
        drive(1, 0, '0, 0);
        model(1, 0, '0, 0);
        tick;
        for (int c = 0; c < 800; c++) begin
            bit r, dv, s;
            logic [DW-1:0] d;
            r  = ($urandom_range(0, 99) < 2);
            dv = ($urandom_range(0, 99) < 55);
            s  = ($urandom_range(0, 99) < 12);
            d  = ($urandom_range(0, 1) == 1) ? DW'($urandom_range(0, 7))
                                             : DW'($urandom);
            drive(r, dv, d, s);
            model(r, dv, d, s);
            tick;
            chk_all($sformatf("rand%0d", c), m_dv, m_dout, m_last,
                    m_busy, m_words.size());
`ifdef DESCENDING_EMITTER_OVERFLOW_EN
            chk($sformatf("rand%0d.overflow", c),
                DW'(bus.overflow), DW'(m_ovf));
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/descending_emitter.md
DESCENDING_EMITTER -- requirements
Module: descending_emitter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the unsigned word width of din/dout.
REQ-002 The block SHALL have parameter DEPTH, default 8, giving the buffer capacity in words (power of two, >= 2).
REQ-003 The block SHALL have one clock, clk; reset is synchronous and active-high.
REQ-004 Port: clk  input  1  rising-edge clock for all state.
REQ-005 Port: reset  input  1  synchronous active-high reset.
REQ-006 Port: din  input  DATA_WIDTH  unsigned word to load.
REQ-007 Port: din_valid  input  1  din is written to the buffer this cycle.
REQ-008 Port: start  input  1  request to emit the buffered words in descending order.
REQ-009 Port: dout  output  DATA_WIDTH  emitted word (registered).
REQ-010 Port: dout_valid  output  1  dout holds an emitted word this cycle.
REQ-011 Port: last  output  1  dout is the final word of the emission (coincides with dout_valid).
REQ-012 Port: busy  output  1  high while in EMIT.
REQ-013 Port: count  output  $clog2(DEPTH)+1  number of words currently loaded.

Function
REQ-014 The block SHALL implement states LOAD and EMIT; reset enters LOAD.
REQ-015 In LOAD, din_valid with count<DEPTH SHALL store din at index count and increment count on the same edge.
REQ-016 In LOAD, din_valid with count==DEPTH SHALL be dropped; buffer and count unchanged.
REQ-017 In LOAD, start with count>0 (after applying a same-cycle din_valid) SHALL move to EMIT at that edge; the same-cycle din word is included in the emission.
REQ-018 In LOAD, start with count==0 and no same-cycle din_valid SHALL be ignored.
REQ-019 Each edge in EMIT SHALL register the maximum unsigned value among un-emitted entries into dout, set dout_valid, and mark that entry emitted.
REQ-020 Ties SHALL be resolved by emitting the lowest index first; duplicate values are each emitted once per occurrence.
REQ-021 With start high in cycle c, dout_valid SHALL be high in cycles c+2 through c+1+N (N = count), one word per cycle, with no gaps.
REQ-022 last SHALL be high with the N-th word only; at that edge the state SHALL return to LOAD with count=0 and all emitted marks cleared.
REQ-023 din_valid and start SHALL be ignored while in EMIT.
REQ-024 busy SHALL be high from the edge entering EMIT up to, but not including, the edge emitting the last word.
REQ-025 Outside emission cycles, dout_valid and last SHALL be 0, and dout SHALL hold its last emitted value.

Reset
REQ-026 Reset SHALL force state LOAD, count=0, all emitted marks clear, dout=0, dout_valid=0, last=0, busy=0; buffer contents need not be cleared.
REQ-027 Reset asserted mid-EMIT SHALL abort the emission at that edge; the next cycle shows dout_valid=0 and count=0.
REQ-028 Reset SHALL take priority over din_valid and start in the same cycle.

Configuration
REQ-029 Macro DESCENDING_EMITTER_OVERFLOW_EN, when defined, SHALL add output overflow (1 bit), set when a din_valid is dropped under REQ-016, sticky until reset or the edge that enters EMIT.
REQ-030 Without DESCENDING_EMITTER_OVERFLOW_EN, the overflow port and its logic SHALL be absent; dropping behaviour is unchanged.

Verification
REQ-031 Load 0x02,0x06,0x00,0x0e,0x0c,0x01, then start -> dout 0x0e,0x0c,0x06,0x02,0x01,0x00 on consecutive cycles, last with 0x00, count returns to 0.
REQ-032 Load 0x05,0x05,0x03, then start -> 0x05,0x05,0x03; after it, load 0x07, start -> single word 0x07 with last and dout_valid high together.
REQ-033 Start with count==0 -> no dout_valid in the next 4 cycles; state remains LOAD.
REQ-034 Load 9 words into DEPTH=8 -> count saturates at 8; 9th word absent from output; overflow=1 when the macro is defined.
REQ-035 Assert reset during the third emitted word of a 6-word emission -> dout_valid=0, busy=0, count=0 next cycle; a fresh load/emit then works correctly.
REQ-036 Assert din_valid (0x0f) and start in the same cycle after loading 0x01 -> emits 0x0f then 0x01.
